// File: rtl/sum_diff_recombiner_if.sv
// Sample/flag bundle between the sum/difference path, the recombiner and the I/Q DAC formatter.
interface sum_diff_recombiner_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] sum_in;
  logic             sum_valid;
  logic [WIDTH-1:0] diff_in;
  logic             diff_valid;
  logic             clear_err;
  logic [WIDTH-1:0] i_out;
  logic [WIDTH-1:0] q_out;
  logic             output_ready;
  logic             overrun;
  logic             saturated;

  modport master (
    output sum_in, sum_valid, diff_in, diff_valid, clear_err,
    input  i_out, q_out, output_ready, overrun, saturated
  );

  modport slave (
    input  sum_in, sum_valid, diff_in, diff_valid, clear_err,
    output i_out, q_out, output_ready, overrun, saturated
  );
endinterface

// File: rtl/sum_diff_recombiner.sv
// Pairs halved-sum S and halved-difference D words and rebuilds I=S+D, Q=S-D with saturation.
module sum_diff_recombiner #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 M100CLK,
  input logic                 reset,
  sum_diff_recombiner_if.slave bus
);

  localparam int unsigned WE = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] hs_q, hs_d, hd_q, hd_d;
  logic             hs_full_q, hs_full_d, hd_full_q, hd_full_d;
  logic [WE-1:0]    ip_q, ip_d, qp_q, qp_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] i_q, i_d, q_q, q_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             sat_q, sat_d;

  logic          fire;
  logic          ovr_set;
  logic          clip_i, clip_q;
  logic [WE-1:0] s_ext, d_ext;

  // Top two bits differing means the WIDTH+1 result does not fit in WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_val(input logic [WE-1:0] v);
    if (v[WE-1] != v[WE-2]) return v[WE-1] ? MIN_NEG : MAX_POS;
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    hs_d       = hs_q;
    hd_d       = hd_q;
    hs_full_d  = hs_full_q;
    hd_full_d  = hd_full_q;
    ip_d       = ip_q;
    qp_d       = qp_q;
    s1_valid_d = 1'b0;
    i_d        = i_q;
    q_d        = q_q;
    ready_d    = 1'b0;
    clip_i     = 1'b0;
    clip_q     = 1'b0;

    fire  = hs_full_q & hd_full_q;
    s_ext = {hs_q[WIDTH-1], hs_q};
    d_ext = {hd_q[WIDTH-1], hd_q};

    // A reload on the same edge a pair leaves is a refill, not an overrun.
    ovr_set = ~fire & ((bus.sum_valid & hs_full_q) | (bus.diff_valid & hd_full_q));

    if (bus.sum_valid)  hs_d = bus.sum_in;
    if (bus.diff_valid) hd_d = bus.diff_in;

    if (fire) begin
      hs_full_d  = bus.sum_valid;
      hd_full_d  = bus.diff_valid;
      ip_d       = WE'(s_ext + d_ext);
      qp_d       = WE'(s_ext - d_ext);
      s1_valid_d = 1'b1;
    end else begin
      if (bus.sum_valid)  hs_full_d = 1'b1;
      if (bus.diff_valid) hd_full_d = 1'b1;
    end

    if (s1_valid_q) begin
      i_d     = sat_val(ip_q);
      q_d     = sat_val(qp_q);
      clip_i  = ip_q[WE-1] != ip_q[WE-2];
      clip_q  = qp_q[WE-1] != qp_q[WE-2];
      ready_d = 1'b1;
    end

    // Set wins over a simultaneous clear.
    overrun_d = (overrun_q & ~bus.clear_err) | ovr_set;
    sat_d     = (sat_q & ~bus.clear_err) | clip_i | clip_q;
  end

  always_ff @(posedge M100CLK or negedge reset) begin
    if (!reset) begin
      hs_q       <= '0;
      hd_q       <= '0;
      hs_full_q  <= 1'b0;
      hd_full_q  <= 1'b0;
      ip_q       <= '0;
      qp_q       <= '0;
      s1_valid_q <= 1'b0;
      i_q        <= '0;
      q_q        <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      hd_q       <= hd_d;
      hs_full_q  <= hs_full_d;
      hd_full_q  <= hd_full_d;
      ip_q       <= ip_d;
      qp_q       <= qp_d;
      s1_valid_q <= s1_valid_d;
      i_q        <= i_d;
      q_q        <= q_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.i_out        = i_q;
  assign bus.q_out        = q_q;
  assign bus.output_ready = ready_q;
  assign bus.overrun      = overrun_q;
  assign bus.saturated    = sat_q;

endmodule
